// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: snoops core stores, queues TXDATA bytes in a FIFO and sends them 8N1, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module mmio_uart_tx #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] RdData,
    output logic        tx,
    output logic        busy
);
    localparam int unsigned   CW          = $clog2(CLK_DIV);
    localparam int unsigned   AW          = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX     = CW'(CLK_DIV - 1);
    localparam logic [AW:0]   DEPTH_CNT   = (AW+1)'(FIFO_DEPTH);
    localparam logic [29:0]   TXDATA_WORD = BASE_ADDR[31:2];
    localparam logic [29:0]   STATUS_WORD = BASE_ADDR[31:2] + 30'd1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic [29:0]   addr_word;
    logic          full, empty, push_req, push, pop, status_wr, ovf;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick, tx_next;
    logic [3:0]    count_sat;
`ifdef UART_TX_PARITY_EN
    logic          par_bit;
`endif
    logic          unused_bits;

    assign unused_bits = ^{WriteData[31:8], DataAdr[1:0]};
    assign addr_word   = DataAdr[31:2];
    assign full        = (count == DEPTH_CNT);
    assign empty       = (count == '0);
    assign push_req    = MemWrite && (addr_word == TXDATA_WORD);
    assign push        = push_req && !full;
    assign status_wr   = MemWrite && (addr_word == STATUS_WORD);
    assign tick        = (cnt == '0);

    // Fullness is judged on the pre-edge count, so a push while full is lost even if a pop coincides.
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + (AW+1)'(1);
        else if (pop && !push)
            count_next = count - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            if (push_req && full)
                ovf <= 1'b1;
            else if (status_wr)
                ovf <= 1'b0;
        end
    end

    // NOTE: FIFO storage is not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= WriteData[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (!empty) state_next = START;
            START:  if (tick) state_next = DATA;
            DATA:   if (tick && bit_idx == 3'd7)
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
            PARITY: if (tick) state_next = STOP;
`else
                        state_next = STOP;
`endif
            STOP:   if (tick) state_next = empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        tx_next = tx;
        unique case (state)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                tx_next = 1'b0;
            end
            START: if (tick) tx_next = shreg[0];
            DATA: if (tick) begin
`ifdef UART_TX_PARITY_EN
                if (bit_idx == 3'd7) tx_next = par_bit;
`else
                if (bit_idx == 3'd7) tx_next = 1'b1;
`endif
                else                 tx_next = shreg[1];
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) tx_next = 1'b1;
`endif
            STOP: if (tick) begin
                pop     = !empty;
                tx_next = empty;
            end
            default: tx_next = 1'b1;
        endcase
    end

    // The baud counter reloads on every bit or state change, so bit lengths never drift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx      <= 1'b1;
            busy    <= 1'b0;
            cnt     <= CNT_MAX;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            tx   <= tx_next;
            busy <= (state_next != IDLE) || (count_next != '0);
            if (pop || (state != IDLE && tick))
                cnt <= CNT_MAX;
            else if (state != IDLE)
                cnt <= cnt - CW'(1);
            if (pop) begin
                shreg   <= mem[rd_ptr];
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                par_bit <= ^mem[rd_ptr];
`endif
            end else if (state == DATA && tick) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        count_sat = (32'(count) > 32'd15) ? 4'd15 : 4'(count);
        RdData    = '0;
        if (addr_word == STATUS_WORD)
            RdData = {24'd0, count_sat, ovf, (state != IDLE), empty, full};
    end

endmodule
